rr_arbiter_4x1: RTL and testbench
=================================

Name: rr_arbiter_4x1

Overview:
- Round-robin arbiter that sits directly upstream of the 4-to-1 output mux.
- Drains four first-word-fall-through lane FIFOs, one word per cycle.
- Presents each drained word to the mux on its lane's data/valid pair, with at most one valid high per cycle.
- Honours back-pressure from the downstream FIFO's almost-full flag.

Parameters:
- DATA_SIZE, 12, width of every data word.
- CNT_SIZE, 8, width of the per-lane grant counters; used only with ARB_GRANT_CNT_EN.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- data_fifo0..data_fifo3  input  DATA_SIZE each  head word of lane FIFO 0..3 (FWFT, valid whenever not empty).
- empty0..empty3  input  1 each  lane FIFO 0..3 empty flag.
- almost_full_out  input  1  downstream FIFO almost-full; 1 = do not grant.
- pop0..pop3  output  1 each  combinational pop to lane FIFO 0..3.
- data_out0..data_out3  output  DATA_SIZE each  registered word to mux input 0..3.
- valid0..valid3  output  1 each  registered valid to mux input 0..3; one-hot or all-zero.
- grant_cnt0..grant_cnt3  output  CNT_SIZE each  present only with ARB_GRANT_CNT_EN.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - valid0..3=0, data_out0..3=0.
  - Priority pointer ptr=0, state=IDLE, grant counters=0.
  - pop0..3 forced 0 combinationally for as long as reset_L=0.
- State machine, 2-bit state register:
  - IDLE: all lanes empty or reset just released. Goes to SERVE when any emptyN=0 and almost_full_out=0. Goes to STALL when any lane is non-empty and almost_full_out=1.
  - SERVE: one grant per cycle. Goes to STALL when almost_full_out=1. Goes to IDLE when all lanes are empty.
  - STALL: no grants. Goes to SERVE when almost_full_out=0 and any lane is non-empty. Goes to IDLE when almost_full_out=0 and all lanes are empty.
- Grant rule (combinational, per cycle):
  - Grants are allowed only when reset_L=1, almost_full_out=0 and at least one emptyN=0. This is evaluated on the current-cycle inputs, not gated by the registered state.
  - Lanes are searched in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The first non-empty lane g is granted and popN=1 only for N=g. Never more than one pop high.
  - popN is never asserted while emptyN=1.
- Registered output, latency 1 cycle from pop to valid:
  - On the clock edge after popN=1: data_outN<=data_fifoN, validN<=1; all other valids<=0.
  - On a cycle with no grant, all valids<=0 on the next edge.
  - data_out of non-granted lanes holds its previous value.
- Pointer:
  - After a grant to lane g, ptr<=(g+1) mod 4 (wraps 3->0).
  - No grant means ptr holds.
- Boundary cases:
  - All four lanes non-empty continuously: grants cycle 0,1,2,3,0,... with no gaps.
  - Only one lane non-empty: it is granted every cycle.
  - A lane that becomes empty is skipped in the same cycle.
  - almost_full_out rising: the pop is blocked in the same cycle; the word popped in the previous cycle still produces its valid.
  - Reset mid-transfer: a pending valid is dropped immediately and the pointer returns to 0.

Optional Feature:
- Macro: ARB_GRANT_CNT_EN.
- When defined:
  - grant_cnt0..3 ports exist.
  - grant_cntN increments by 1 on each edge where popN=1 and wraps to 0 at overflow (2^CNT_SIZE).
  - Counters are cleared by reset_L=0.
- When not defined: the ports and counters are absent. Arbitration and data/valid behaviour are identical in both builds.

Test Plan:
- Reset release with all lanes empty -> pop0..3=0, valid0..3=0, data_out0..3=0, state stays IDLE for 10 cycles.
- Lanes 0..3 each preloaded with 2 words (0x0A1, 0x0A2 / 0x0B1, 0x0B2 / 0x0C1, 0x0C2 / 0x0D1, 0x0D2), almost_full_out=0 -> valids one-hot in order 0,1,2,3,0,1,2,3; data sequence 0x0A1, 0x0B1, 0x0C1, 0x0D1, 0x0A2, 0x0B2, 0x0C2, 0x0D2; 8 consecutive valid cycles; then IDLE.
- Only lane 2 non-empty with 3 words, ptr=0 -> pop2 high 3 consecutive cycles; valid2 high 3 cycles starting one cycle later; ptr ends at 3.
- Mid-stream almost_full_out=1 for 4 cycles -> pops drop to 0 the same cycle; exactly one trailing valid; then no valids for 4 cycles; round-robin resumes from the next lane in sequence.
- reset_L pulsed low for half a cycle while valid1=1 -> valid1 and data_out1 clear immediately, without waiting for a clock edge; first grant after release goes to the lowest-indexed non-empty lane.
- ARB_GRANT_CNT_EN build, CNT_SIZE=8, lane 0 popped 257 times -> grant_cnt0=1 after wrap; grant_cnt1..3 unchanged.

Source files
------------

// File: rtl/rr_arbiter_4x1.sv
// rr_arbiter_4x1: round-robin drain of four FWFT lane FIFOs into the 4:1 mux.
// Build option: define ARB_GRANT_CNT_EN to add per-lane grant counters.
module rr_arbiter_4x1 #(
    parameter int DATA_SIZE = 12
`ifdef ARB_GRANT_CNT_EN
    ,
    parameter int CNT_SIZE  = 8
`endif
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic [DATA_SIZE-1:0] data_fifo0,
    input  logic [DATA_SIZE-1:0] data_fifo1,
    input  logic [DATA_SIZE-1:0] data_fifo2,
    input  logic [DATA_SIZE-1:0] data_fifo3,
    input  logic                 empty0,
    input  logic                 empty1,
    input  logic                 empty2,
    input  logic                 empty3,
    input  logic                 almost_full_out,
    output logic                 pop0,
    output logic                 pop1,
    output logic                 pop2,
    output logic                 pop3,
    output logic [DATA_SIZE-1:0] data_out0,
    output logic [DATA_SIZE-1:0] data_out1,
    output logic [DATA_SIZE-1:0] data_out2,
    output logic [DATA_SIZE-1:0] data_out3,
    output logic                 valid0,
    output logic                 valid1,
    output logic                 valid2,
    output logic                 valid3
`ifdef ARB_GRANT_CNT_EN
    ,
    output logic [CNT_SIZE-1:0]  grant_cnt0,
    output logic [CNT_SIZE-1:0]  grant_cnt1,
    output logic [CNT_SIZE-1:0]  grant_cnt2,
    output logic [CNT_SIZE-1:0]  grant_cnt3
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        STALL = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           ptr_q, ptr_d;
    logic [3:0]           valid_q;
    logic [DATA_SIZE-1:0] data_q [4];
    logic [DATA_SIZE-1:0] din [4];

    logic [3:0] req;
    logic [3:0] pop;
    logic       any_req;
    logic       grant_en;
    logic       found;
    logic [1:0] gnt_idx;
    logic [1:0] idx;

    assign din[0] = data_fifo0;
    assign din[1] = data_fifo1;
    assign din[2] = data_fifo2;
    assign din[3] = data_fifo3;

    assign req      = ~{empty3, empty2, empty1, empty0};
    assign any_req  = |req;
    // Grants follow the live inputs, not the registered state.
    assign grant_en = reset_L & ~almost_full_out & any_req;

    // Search lanes starting at the pointer and take the first non-empty one.
    always_comb begin
        found   = 1'b0;
        gnt_idx = ptr_q;
        idx     = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign pop   = (grant_en && found) ? (4'b0001 << gnt_idx) : 4'b0000;
    assign ptr_d = (grant_en && found) ? gnt_idx + 2'd1 : ptr_q;

    assign pop0 = pop[0];
    assign pop1 = pop[1];
    assign pop2 = pop[2];
    assign pop3 = pop[3];

    // Next-state logic for the idle/serve/stall controller.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_req)
                    state_d = almost_full_out ? STALL : SERVE;
            end
            SERVE: begin
                if (almost_full_out)
                    state_d = STALL;
                else if (!any_req)
                    state_d = IDLE;
            end
            STALL: begin
                if (!almost_full_out)
                    state_d = any_req ? SERVE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer and the one-cycle-latency output registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            valid_q <= 4'b0000;
            for (int i = 0; i < 4; i++)
                data_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= pop;
            for (int i = 0; i < 4; i++)
                if (pop[i])
                    data_q[i] <= din[i];
        end
    end

    assign valid0 = valid_q[0];
    assign valid1 = valid_q[1];
    assign valid2 = valid_q[2];
    assign valid3 = valid_q[3];

    assign data_out0 = data_q[0];
    assign data_out1 = data_q[1];
    assign data_out2 = data_q[2];
    assign data_out3 = data_q[3];

`ifdef ARB_GRANT_CNT_EN
    logic [CNT_SIZE-1:0] cnt_q [4];

    // Count pops per lane; counters wrap naturally at 2^CNT_SIZE.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < 4; i++)
                cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (pop[i])
                    cnt_q[i] <= cnt_q[i] + CNT_SIZE'(1);
        end
    end

    assign grant_cnt0 = cnt_q[0];
    assign grant_cnt1 = cnt_q[1];
    assign grant_cnt2 = cnt_q[2];
    assign grant_cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_rr_arbiter_4x1.sv
// tb_rr_arbiter_4x1: directed scoreboard bench for rr_arbiter_4x1.
// Lane FIFOs are modelled as queues; expected words are queued per test.
module tb_rr_arbiter_4x1;

    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic [DW-1:0] data_fifo0, data_fifo1, data_fifo2, data_fifo3;
    logic          empty0, empty1, empty2, empty3;
    logic          almost_full_out = 1'b0;
    logic          pop0, pop1, pop2, pop3;
    logic [DW-1:0] data_out0, data_out1, data_out2, data_out3;
    logic          valid0, valid1, valid2, valid3;
`ifdef ARB_GRANT_CNT_EN
    logic [7:0]    grant_cnt0, grant_cnt1, grant_cnt2, grant_cnt3;
`endif

    always #5 clk = ~clk;

    rr_arbiter_4x1 #(
        .DATA_SIZE(DW)
`ifdef ARB_GRANT_CNT_EN
        ,
        .CNT_SIZE(8)
`endif
    ) dut (
        .clk(clk),
        .reset_L(reset_L),
        .data_fifo0(data_fifo0),
        .data_fifo1(data_fifo1),
        .data_fifo2(data_fifo2),
        .data_fifo3(data_fifo3),
        .empty0(empty0),
        .empty1(empty1),
        .empty2(empty2),
        .empty3(empty3),
        .almost_full_out(almost_full_out),
        .pop0(pop0),
        .pop1(pop1),
        .pop2(pop2),
        .pop3(pop3),
        .data_out0(data_out0),
        .data_out1(data_out1),
        .data_out2(data_out2),
        .data_out3(data_out3),
        .valid0(valid0),
        .valid1(valid1),
        .valid2(valid2),
        .valid3(valid3)
`ifdef ARB_GRANT_CNT_EN
        ,
        .grant_cnt0(grant_cnt0),
        .grant_cnt1(grant_cnt1),
        .grant_cnt2(grant_cnt2),
        .grant_cnt3(grant_cnt3)
`endif
    );

    logic [DW-1:0] q0[$], q1[$], q2[$], q3[$];
    int            exp_lane[$];
    logic [DW-1:0] exp_data[$];
    int            vcyc[$];
    int            cyc = 0;
    int            n_chk = 0;
    int            n_fail = 0;

    logic [3:0] pops, valids, empties;
    logic [3:0] pop_s;
    int         m_ln;
    logic [DW-1:0] m_dv;
    int         m_el;
    logic [DW-1:0] m_ed;

    assign pops    = {pop3, pop2, pop1, pop0};
    assign valids  = {valid3, valid2, valid1, valid0};
    assign empties = {empty3, empty2, empty1, empty0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic push(input int lane, input logic [DW-1:0] w);
        case (lane)
            0: q0.push_back(w);
            1: q1.push_back(w);
            2: q2.push_back(w);
            default: q3.push_back(w);
        endcase
    endtask

    task automatic expect_word(input int lane, input logic [DW-1:0] w);
        exp_lane.push_back(lane);
        exp_data.push_back(w);
    endtask

    task automatic refresh();
        empty0 = (q0.size() == 0);
        empty1 = (q1.size() == 0);
        empty2 = (q2.size() == 0);
        empty3 = (q3.size() == 0);
        data_fifo0 = (q0.size() != 0) ? q0[0] : '0;
        data_fifo1 = (q1.size() != 0) ? q1[0] : '0;
        data_fifo2 = (q2.size() != 0) ? q2[0] : '0;
        data_fifo3 = (q3.size() != 0) ? q3[0] : '0;
    endtask

    // Lane FIFO model: sample pops late in the cycle, retire heads after the edge.
    initial begin
        refresh();
        forever begin
            @(negedge clk);
            #4;
            pop_s = pops;
            @(posedge clk);
            #1;
            if (pop_s[0] && q0.size() != 0) void'(q0.pop_front());
            if (pop_s[1] && q1.size() != 0) void'(q1.pop_front());
            if (pop_s[2] && q2.size() != 0) void'(q2.pop_front());
            if (pop_s[3] && q3.size() != 0) void'(q3.pop_front());
            #2;
            refresh();
        end
    end

    // Monitor: protocol checks each cycle, scoreboard compare on any valid.
    initial begin
        forever begin
            @(negedge clk);
            check("pop_onehot0", 64'($onehot0(pops)), 64'd1);
            check("pop_while_empty", 64'(pops & empties), 64'd0);
            check("valid_onehot0", 64'($onehot0(valids)), 64'd1);
            if (valids != 4'b0000) begin
                vcyc.push_back(cyc);
                m_ln = 0;
                for (int i = 3; i >= 0; i--)
                    if (valids[i]) m_ln = i;
                case (m_ln)
                    0: m_dv = data_out0;
                    1: m_dv = data_out1;
                    2: m_dv = data_out2;
                    default: m_dv = data_out3;
                endcase
                if (exp_lane.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_valid: lane %0d data %0h, expected none",
                             m_ln, m_dv);
                end else begin
                    m_el = exp_lane.pop_front();
                    m_ed = exp_data.pop_front();
                    check("valid_lane", 64'(m_ln), 64'(m_el));
                    check("data_out", 64'(m_dv), 64'(m_ed));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int budget, input string nm);
        int n;
        n = 0;
        while (exp_lane.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_lane.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_drain: %0d words outstanding, expected 0",
                     nm, exp_lane.size());
            exp_lane.delete();
            exp_data.delete();
        end
        repeat (3) tick();
    endtask

    function automatic int span();
        if (vcyc.size() == 0) return -1;
        return vcyc[vcyc.size()-1] - vcyc[0];
    endfunction

    function automatic int gap(input int a, input int b);
        if (vcyc.size() <= b) return -1;
        return vcyc[b] - vcyc[a];
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        check("reset_valid", 64'(valids), 64'd0);
        check("reset_pop", 64'(pops), 64'd0);
        reset_L = 1'b1;

        // Idle after reset release with every lane empty.
        for (int i = 0; i < 10; i++) begin
            tick();
            #2;
            check("idle_pop", 64'(pops), 64'd0);
            check("idle_valid", 64'(valids), 64'd0);
            check("idle_dout", 64'({data_out3, data_out2, data_out1, data_out0}), 64'd0);
        end

        // All four lanes loaded with two words: strict 0,1,2,3 rotation.
        tick();
        vcyc.delete();
        push(0, 12'h0A1); push(0, 12'h0A2);
        push(1, 12'h0B1); push(1, 12'h0B2);
        push(2, 12'h0C1); push(2, 12'h0C2);
        push(3, 12'h0D1); push(3, 12'h0D2);
        expect_word(0, 12'h0A1); expect_word(1, 12'h0B1);
        expect_word(2, 12'h0C1); expect_word(3, 12'h0D1);
        expect_word(0, 12'h0A2); expect_word(1, 12'h0B2);
        expect_word(2, 12'h0C2); expect_word(3, 12'h0D2);
        drain(40, "rr4");
        check("rr4_count", 64'(vcyc.size()), 64'd8);
        check("rr4_span", 64'(span()), 64'd7);
        check("rr4_idle_after", 64'(valids), 64'd0);

        // Single busy lane: granted back to back.
        vcyc.delete();
        push(2, 12'h2E1); push(2, 12'h2E2); push(2, 12'h2E3);
        expect_word(2, 12'h2E1); expect_word(2, 12'h2E2); expect_word(2, 12'h2E3);
        drain(40, "lane2");
        check("lane2_count", 64'(vcyc.size()), 64'd3);
        check("lane2_span", 64'(span()), 64'd2);

        // Back-pressure mid-stream; pointer is 3 after the single-lane run.
        vcyc.delete();
        push(0, 12'h401); push(0, 12'h402);
        push(1, 12'h411); push(1, 12'h412);
        push(2, 12'h421); push(2, 12'h422);
        push(3, 12'h431); push(3, 12'h432);
        expect_word(3, 12'h431); expect_word(0, 12'h401);
        expect_word(1, 12'h411); expect_word(2, 12'h421);
        expect_word(3, 12'h432); expect_word(0, 12'h402);
        expect_word(1, 12'h412); expect_word(2, 12'h422);
        tick();
        tick();
        almost_full_out = 1'b1;
        #2;
        check("af_pop_blocked", 64'(pops), 64'd0);
        repeat (4) tick();
        almost_full_out = 1'b0;
        drain(40, "af");
        check("af_count", 64'(vcyc.size()), 64'd8);
        check("af_trailing_valid", 64'(gap(0, 1)), 64'd1);
        check("af_gap", 64'(gap(1, 2)), 64'd5);

        // Reset pulse while lane 1 is presenting; pointer is 3 here.
        vcyc.delete();
        push(0, 12'h501); push(0, 12'h502);
        push(1, 12'h511);
        push(2, 12'h521);
        push(3, 12'h531);
        expect_word(3, 12'h531); expect_word(0, 12'h501);
        expect_word(0, 12'h502); expect_word(2, 12'h521);
        tick();
        tick();
        tick();
        check("rst_pre_valid1", 64'(valid1), 64'd1);
        check("rst_pre_dout1", 64'(data_out1), 64'h511);
        reset_L = 1'b0;
        #2;
        check("rst_valid1", 64'(valid1), 64'd0);
        check("rst_dout1", 64'(data_out1), 64'd0);
        check("rst_dout_all", 64'({data_out3, data_out2, data_out0}), 64'd0);
        check("rst_pop", 64'(pops), 64'd0);
        #3;
        reset_L = 1'b1;
        drain(40, "rst");

`ifdef ARB_GRANT_CNT_EN
        // Counter wrap: 257 pops on lane 0 from a cleared state.
        reset_L = 1'b0;
        #2;
        check("cnt_reset", 64'({grant_cnt3, grant_cnt2, grant_cnt1, grant_cnt0}), 64'd0);
        reset_L = 1'b1;
        tick();
        for (int i = 0; i < 257; i++) begin
            push(0, 12'(i + 12'h100));
            expect_word(0, 12'(i + 12'h100));
        end
        drain(400, "cnt");
        check("cnt0_wrap", 64'(grant_cnt0), 64'd1);
        check("cnt123_hold", 64'({grant_cnt3, grant_cnt2, grant_cnt1}), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
